// File: rtl/wb_matmul_engine.sv
// Wishbone-slave N x N integer matrix multiplier: C = A x B, one MAC per clock, results in the C window.
// Latency: single-cycle registered ack/err, no wait states; a run keeps busy high for N^3 clocks, irq pulses at the end.
module wb_matmul_engine #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int ACC_W  = 2*DW + $clog2(N),
  parameter int AW     = 16,
  parameter int A_BASE = 16,
  parameter int B_BASE = A_BASE + N*N,
  parameter int C_BASE = A_BASE + 2*N*N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cyc,
  input  logic          stb,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   dat_mosi,
  output logic [31:0]   dat_miso,
  output logic          ack,
  output logic          err,
  output logic          irq
);
  localparam int NN = N*N;
  localparam int IW = $clog2(N);
  localparam int XW = $clog2(NN);
  localparam logic [AW-1:0] A_LO = AW'(A_BASE);
  localparam logic [AW-1:0] A_HI = AW'(A_BASE + NN);
  localparam logic [AW-1:0] B_LO = AW'(B_BASE);
  localparam logic [AW-1:0] B_HI = AW'(B_BASE + NN);
  localparam logic [AW-1:0] C_LO = AW'(C_BASE);
  localparam logic [AW-1:0] C_HI = AW'(C_BASE + NN);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [DW-1:0]    a_mem [NN];
  logic [DW-1:0]    b_mem [NN];
  logic [ACC_W-1:0] c_mem [NN];
  state_t           state;
  logic             busy, done, signed_mode;
  logic [IW-1:0]    i, j, k;
  logic [ACC_W-1:0] acc;

  logic          req, is_ctrl, is_stat, in_a, in_b, in_c;
  logic [XW-1:0] a_idx, b_idx, c_idx;
  logic          rd_err, wr_err;
  logic [31:0]   rd_dat;

  assign req     = cyc & stb & ~ack & ~err;
  assign is_ctrl = (adr == AW'(0));
  assign is_stat = (adr == AW'(1));
  assign in_a    = (adr >= A_LO) && (adr < A_HI);
  assign in_b    = (adr >= B_LO) && (adr < B_HI);
  assign in_c    = (adr >= C_LO) && (adr < C_HI);
  assign a_idx   = XW'(adr - A_LO);
  assign b_idx   = XW'(adr - B_LO);
  assign c_idx   = XW'(adr - C_LO);

  always_comb begin
    rd_err = 1'b1;
    wr_err = 1'b1;
    rd_dat = '0;
    if (is_ctrl) begin
      rd_err = 1'b0;
      wr_err = busy;
      rd_dat = {30'b0, signed_mode, 1'b0};
    end else if (is_stat) begin
      rd_err = 1'b0;
      wr_err = 1'b0;
      rd_dat = {30'b0, done, busy};
    end else if (in_a) begin
      rd_err = 1'b0;
      wr_err = busy;
      rd_dat = 32'(a_mem[a_idx]);
    end else if (in_b) begin
      rd_err = 1'b0;
      wr_err = busy;
      rd_dat = 32'(b_mem[b_idx]);
    end else if (in_c) begin
      // Results are only coherent once a run has finished.
      rd_err = busy;
      rd_dat = signed_mode ? 32'($signed(c_mem[c_idx])) : 32'(c_mem[c_idx]);
    end
  end

  logic [XW-1:0]          ra_idx, rb_idx, wc_idx;
  logic [DW-1:0]          a_op, b_op;
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]        prod_u;
  logic [31:0]            prod_x;
  logic [ACC_W-1:0]       acc_next;

  assign ra_idx   = XW'(32'(i)*N + 32'(k));
  assign rb_idx   = XW'(32'(k)*N + 32'(j));
  assign wc_idx   = XW'(32'(i)*N + 32'(j));
  assign a_op     = a_mem[ra_idx];
  assign b_op     = b_mem[rb_idx];
  assign prod_s   = $signed({{DW{a_op[DW-1]}}, a_op}) * $signed({{DW{b_op[DW-1]}}, b_op});
  assign prod_u   = {{DW{1'b0}}, a_op} * {{DW{1'b0}}, b_op};
  assign prod_x   = signed_mode ? 32'(prod_s) : 32'(prod_u);
  assign acc_next = acc + prod_x[ACC_W-1:0];

  logic unused_bits;
  assign unused_bits = &{1'b0, sel[3:1], dat_mosi, prod_x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_miso    <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      irq         <= 1'b0;
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      signed_mode <= 1'b0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      for (int n = 0; n < NN; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
    end else begin
      ack      <= 1'b0;
      err      <= 1'b0;
      irq      <= 1'b0;
      dat_miso <= '0;
      if (req) begin
        if (we ? wr_err : rd_err) begin
          err <= 1'b1;
        end else begin
          ack <= 1'b1;
          if (!we) begin
            dat_miso <= rd_dat;
          end else if (is_ctrl) begin
            signed_mode <= dat_mosi[1];
            if (dat_mosi[0]) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              acc   <= '0;
              i     <= '0;
              j     <= '0;
              k     <= '0;
            end
          end else if (in_a && sel[0]) begin
            a_mem[a_idx] <= dat_mosi[DW-1:0];
          end else if (in_b && sel[0]) begin
            b_mem[b_idx] <= dat_mosi[DW-1:0];
          end
        end
      end
      // Bus writes to A/B/CTRL are refused while running, so nothing below races with them.
      if (state == RUN) begin
        if (k != LAST) begin
          acc <= acc_next;
          k   <= k + IW'(1);
        end else begin
          c_mem[wc_idx] <= acc_next;
          acc <= '0;
          k   <= '0;
          if (j != LAST) begin
            j <= j + IW'(1);
          end else begin
            j <= '0;
            if (i != LAST) begin
              i <= i + IW'(1);
            end else begin
              i     <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              irq   <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_matmul_engine.sv
// Directed and randomized bench for wb_matmul_engine; expected C values come from a plain integer matrix product.
module tb_wb_matmul_engine;
  localparam int N      = 3;
  localparam int DW     = 8;
  localparam int ACC_W  = 2*DW + $clog2(N);
  localparam int AW     = 16;
  localparam int A_BASE = 16;
  localparam int B_BASE = A_BASE + N*N;
  localparam int C_BASE = A_BASE + 2*N*N;
  localparam int NN     = N*N;
  localparam int RUN_T  = N*N*N*10 + 5;

  logic          clk = 1'b0;
  logic          rst, cyc, stb, we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_mosi, dat_miso;
  logic          ack, err, irq;

  wb_matmul_engine #(.N(N), .DW(DW), .ACC_W(ACC_W), .AW(AW), .A_BASE(A_BASE),
                     .B_BASE(B_BASE), .C_BASE(C_BASE)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .sel(sel), .adr(adr),
    .dat_mosi(dat_mosi), .dat_miso(dat_miso), .ack(ack), .err(err), .irq(irq)
  );

  always #5 clk = ~clk;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  irq_cnt  = 0;
  time t_irq    = 0;
  time t_req    = 0;
  time t_start  = 0;
  int  ma [NN];
  int  mb [NN];

  always @(negedge clk) if (irq === 1'b1) begin irq_cnt++; t_irq = $time; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input int a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic ak, output logic er);
    cyc = 1'b1; stb = 1'b1; we = w; adr = AW'(a); dat_mosi = d; sel = s;
    @(posedge clk);
    t_req = $time;
    #1;
    ak = ack; er = err; rd = dat_miso;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_chk(input string tag, input int a, input logic [31:0] d, input logic [3:0] s, input logic exp_err);
    logic [31:0] rd; logic ak, er;
    bus(1'b1, a, d, s, rd, ak, er);
    chk(tag, {30'b0, er, ak}, exp_err ? 32'd2 : 32'd1);
  endtask

  task automatic rd_chk(input string tag, input int a, input logic exp_err, input logic [31:0] exp_dat);
    logic [31:0] rd; logic ak, er;
    bus(1'b0, a, 32'h0, 4'hF, rd, ak, er);
    chk(tag, {30'b0, er, ak}, exp_err ? 32'd2 : 32'd1);
    if (!exp_err) chk(tag, rd, exp_dat);
  endtask

  // Reference: integer dot product, reduced modulo 2^ACC_W, then extended as the C window reports it.
  function automatic logic [31:0] ref_c(input int idx, input logic sm);
    longint acc, av, bv;
    logic [63:0] m;
    logic [63:0] mask;
    acc  = 0;
    mask = (64'd1 << ACC_W) - 64'd1;
    for (int kk = 0; kk < N; kk++) begin
      av = ma[(idx / N)*N + kk];
      bv = mb[kk*N + (idx % N)];
      if (sm && av >= 2**(DW-1)) av -= 2**DW;
      if (sm && bv >= 2**(DW-1)) bv -= 2**DW;
      acc += av * bv;
    end
    m = acc;
    m = m & mask;
    if (sm && m[ACC_W-1]) m = m | ~mask;
    return m[31:0];
  endfunction

  task automatic load_mats();
    for (int n = 0; n < NN; n++) wr_chk("load_a", A_BASE + n, ma[n], 4'hF, 1'b0);
    for (int n = 0; n < NN; n++) wr_chk("load_b", B_BASE + n, mb[n], 4'hF, 1'b0);
  endtask

  task automatic wait_done(input int prev);
    for (int c = 0; c < 200 && irq_cnt == prev; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("irq_count", irq_cnt, prev + 1);
    chk("run_latency", 32'(t_irq - t_start), RUN_T);
  endtask

  task automatic check_c(input logic sm);
    for (int n = 0; n < NN; n++) rd_chk("c_elem", C_BASE + n, 1'b0, ref_c(n, sm));
  endtask

  task automatic run_and_check(input logic [31:0] ctrl);
    int prev;
    prev = irq_cnt;
    wr_chk("start", 0, ctrl, 4'hF, 1'b0);
    t_start = t_req;
    wait_done(prev);
    rd_chk("status_done", 1, 1'b0, 32'd2);
    check_c(ctrl[1]);
  endtask

  initial begin
    int prev;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_mosi = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset_outputs", {dat_miso[28:0], ack, err, irq}, 32'd0);
    rd_chk("status_rst", 1, 1'b0, 32'd0);
    rd_chk("c0_rst", C_BASE, 1'b0, 32'd0);
    rd_chk("ctrl_rst", 0, 1'b0, 32'd0);
    rd_chk("a0_rst", A_BASE, 1'b0, 32'd0);
    rd_chk("bad_adr5", 5, 1'b1, 32'd0);
    chk("err_one_cycle", {30'b0, err, ack}, 32'd0);
    rd_chk("bad_adr_past_c", C_BASE + NN, 1'b1, 32'd0);
    wr_chk("wr_c_idle", C_BASE, 32'd5, 4'hF, 1'b1);
    wr_chk("wr_status", 1, 32'd3, 4'hF, 1'b0);
    rd_chk("status_ignored", 1, 1'b0, 32'd0);

    // stb held across the response: ack, gap, ack
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AW'(1);
    @(posedge clk); #1; chk("hold_ack1", {31'b0, ack}, 32'd1);
    @(posedge clk); #1; chk("hold_gap", {30'b0, err, ack}, 32'd0);
    @(posedge clk); #1; chk("hold_ack2", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < NN; n++) begin ma[n] = n + 1; mb[n] = NN - n; end
    load_mats();
    run_and_check(32'd1);
    rd_chk("c00_const", C_BASE, 1'b0, 32'd30);
    rd_chk("c22_const", C_BASE + 8, 1'b0, 32'd90);
    wr_chk("wr_a_sel0", A_BASE, 32'd77, 4'hE, 1'b0);
    rd_chk("a0_sel0_kept", A_BASE, 1'b0, 32'd1);
    wr_chk("ctrl_mode_only", 0, 32'd2, 4'hF, 1'b0);
    rd_chk("ctrl_rd_mode", 0, 1'b0, 32'd2);
    rd_chk("status_no_start", 1, 1'b0, 32'd2);

    for (int n = 0; n < NN; n++) begin ma[n] = 255; mb[n] = 255; end
    load_mats();
    run_and_check(32'd1);
    rd_chk("c_max_const", C_BASE + 4, 1'b0, 32'h0002FA03);

    for (int n = 0; n < NN; n++) begin ma[n] = 255; mb[n] = 2; end
    load_mats();
    run_and_check(32'd3);
    rd_chk("c_signed_const", C_BASE + 7, 1'b0, 32'hFFFFFFFA);
    rd_chk("ctrl_signed", 0, 1'b0, 32'd2);
    run_and_check(32'd1);
    rd_chk("c_unsigned_const", C_BASE + 3, 1'b0, 32'd1530);

    // Bus behaviour while a run is in progress
    for (int n = 0; n < NN; n++) begin ma[n] = n + 1; mb[n] = NN - n; end
    load_mats();
    prev = irq_cnt;
    wr_chk("start_busy", 0, 32'd1, 4'hF, 1'b0);
    t_start = t_req;
    wr_chk("busy_wr_a", A_BASE, 32'd99, 4'hF, 1'b1);
    rd_chk("busy_rd_c", C_BASE, 1'b1, 32'd0);
    rd_chk("busy_status", 1, 1'b0, 32'd1);
    wr_chk("busy_restart", 0, 32'd1, 4'hF, 1'b1);
    wr_chk("busy_wr_b", B_BASE + 2, 32'd5, 4'hF, 1'b1);
    rd_chk("busy_rd_a", A_BASE + 4, 1'b0, 32'd5);
    wait_done(prev);
    rd_chk("a0_after_busy", A_BASE, 1'b0, 32'd1);
    check_c(1'b0);

    // Reset in the middle of a run
    for (int n = 0; n < NN; n++) begin ma[n] = $urandom_range(0, 255); mb[n] = $urandom_range(0, 255); end
    load_mats();
    prev = irq_cnt;
    wr_chk("start_rst", 0, 32'd1, 4'hF, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #2 chk("rst_async_out", {29'b0, ack, err, irq}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < NN; n++) begin ma[n] = 0; mb[n] = 0; end
    rd_chk("status_after_rst", 1, 1'b0, 32'd0);
    rd_chk("ctrl_after_rst", 0, 1'b0, 32'd0);
    rd_chk("a_after_rst", A_BASE + 3, 1'b0, 32'd0);
    check_c(1'b0);
    repeat (30) @(posedge clk); #1;
    chk("no_irq_after_rst", irq_cnt, prev);

    for (int n = 0; n < NN; n++) begin ma[n] = $urandom_range(0, 255); mb[n] = $urandom_range(0, 255); end
    load_mats();
    run_and_check(32'd1);

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < NN; n++) begin ma[n] = $urandom_range(0, 255); mb[n] = $urandom_range(0, 255); end
      load_mats();
      run_and_check((r % 2 == 0) ? 32'd3 : 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
